// File: rtl/syzygy_adc_align_pkg.sv
// Shared types and default timing constants for the ADC capture-phase
// alignment block.
package syzygy_adc_align_pkg;

   localparam int DEF_DATA_WIDTH     = 14;
   localparam int DEF_NUM_STEPS      = 140;
   localparam int DEF_SETTLE_CYCLES  = 16;
   localparam int DEF_COMPARE_CYCLES = 64;
   localparam int DEF_PS_TIMEOUT     = 1024;

   typedef enum logic [3:0] {
      IDLE,
      WAIT_LOCK,
      SETTLE,
      COMPARE,
      STEP,
      WAIT_PS,
      EVAL,
      RETURN,
      DONE
   } align_state_e;

endpackage

// File: rtl/syzygy_adc_eye_tracker.sv
// Longest-passing-run tracker: follows the current run of passing phase
// steps and keeps the earliest longest run seen since the last clear.
module syzygy_adc_eye_tracker
   import syzygy_adc_align_pkg::*;
#(
   parameter int SW = $clog2(DEF_NUM_STEPS + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          valid,
   input  logic          pass,
   input  logic [SW-1:0] step,
   output logic [SW-1:0] eye_start,
   output logic [SW-1:0] eye_width
);

   logic [SW-1:0] cur_start_q, cur_start_d;
   logic [SW-1:0] cur_len_q,   cur_len_d;
   logic [SW-1:0] eye_start_q, eye_start_d;
   logic [SW-1:0] eye_width_q, eye_width_d;
   logic [SW-1:0] run_start;
   logic [SW-1:0] run_len;

   // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
   always_comb begin
      cur_start_d = cur_start_q;
      cur_len_d   = cur_len_q;
      eye_start_d = eye_start_q;
      eye_width_d = eye_width_q;
      run_start   = (cur_len_q == '0) ? step : cur_start_q;
      run_len     = cur_len_q + 1'b1;
      if (clear) begin
         cur_start_d = '0;
         cur_len_d   = '0;
         eye_start_d = '0;
         eye_width_d = '0;
      end else if (valid) begin
         if (pass) begin
            cur_start_d = run_start;
            cur_len_d   = run_len;
            // Strictly longer only, so a tie keeps the earlier window.
            if (run_len > eye_width_q) begin
               eye_start_d = run_start;
               eye_width_d = run_len;
            end
         end else begin
            cur_len_d = '0;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_start_q <= '0;
         cur_len_q   <= '0;
         eye_start_q <= '0;
         eye_width_q <= '0;
      end else begin
         cur_start_q <= cur_start_d;
         cur_len_q   <= cur_len_d;
         eye_start_q <= eye_start_d;
         eye_width_q <= eye_width_d;
      end
   end

   assign eye_start = eye_start_q;
   assign eye_width = eye_width_q;

endmodule

// File: rtl/syzygy_adc_phase_align.sv
// Sweeps the MMCM dynamic phase across one DCO period, scores each step
// against the ADC test pattern, and parks the phase at the widest eye centre.
module syzygy_adc_phase_align
   import syzygy_adc_align_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int NUM_STEPS      = DEF_NUM_STEPS,
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int COMPARE_CYCLES = DEF_COMPARE_CYCLES,
   parameter int PS_TIMEOUT     = DEF_PS_TIMEOUT,
   parameter int SW             = $clog2(NUM_STEPS + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  mmcm_locked,
   input  logic [DATA_WIDTH-1:0] adc_data,
   input  logic [DATA_WIDTH-1:0] pattern,
   input  logic                  ps_done,
   output logic                  ps_en,
   output logic                  ps_incdec,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [SW-1:0]         eye_start,
   output logic [SW-1:0]         eye_width,
   output logic [SW-1:0]         phase_pos
);

   localparam int CNT_MAX = (SETTLE_CYCLES > COMPARE_CYCLES) ? SETTLE_CYCLES : COMPARE_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int TW      = $clog2(PS_TIMEOUT + 1);

   align_state_e  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          match_q, match_d;
   logic [SW-1:0] phase_pos_q, phase_pos_d;
   logic [SW-1:0] target_q, target_d;
   logic          ps_en_q, ps_en_d;
   logic          ps_incdec_q, ps_incdec_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;

   logic          trk_clear;
   logic          trk_valid;
   logic          trk_pass;
   logic          word_match;
   logic          lock_lost;

   assign word_match = (adc_data == pattern);
   assign lock_lost  = !mmcm_locked && !(state_q inside {IDLE, WAIT_LOCK, DONE});

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      timer_d     = timer_q;
      match_d     = match_q;
      phase_pos_d = phase_pos_q;
      target_d    = target_q;
      ps_en_d     = 1'b0;
      ps_incdec_d = ps_incdec_q;
      busy_d      = busy_q;
      done_d      = done_q;
      error_d     = error_q;
      trk_clear   = 1'b0;
      trk_valid   = 1'b0;
      trk_pass    = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               trk_clear = 1'b1;
               done_d    = 1'b0;
               error_d   = 1'b0;
               busy_d    = 1'b1;
               target_d  = '0;
               state_d   = WAIT_LOCK;
            end
         end
         WAIT_LOCK: begin
            if (mmcm_locked) begin
               cnt_d   = '0;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
               cnt_d   = '0;
               match_d = 1'b1;
               state_d = COMPARE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         COMPARE: begin
            if (cnt_q == CW'(COMPARE_CYCLES - 1)) begin
               trk_valid = 1'b1;
               trk_pass  = match_q && word_match;
               state_d   = (phase_pos_q < SW'(NUM_STEPS - 1)) ? STEP : EVAL;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               match_d = match_q && word_match;
            end
         end
         STEP: begin
            ps_en_d     = 1'b1;
            ps_incdec_d = 1'b1;
            timer_d     = '0;
            state_d     = WAIT_PS;
         end
         WAIT_PS: begin
            // ps_done takes priority over a timeout expiring in the same cycle.
            if (ps_done) begin
               phase_pos_d = ps_incdec_q ? phase_pos_q + 1'b1 : phase_pos_q - 1'b1;
               cnt_d       = '0;
               state_d     = ps_incdec_q ? SETTLE : RETURN;
            end else if (timer_q == TW'(PS_TIMEOUT - 1)) begin
               error_d = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = DONE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         EVAL: begin
            if (eye_width != '0) begin
               target_d = eye_start + ((eye_width - 1'b1) >> 1);
            end else begin
               target_d = '0;
               error_d  = 1'b1;
            end
            state_d = RETURN;
         end
         RETURN: begin
            if (phase_pos_q == target_q) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = DONE;
            end else begin
               ps_en_d     = 1'b1;
               ps_incdec_d = 1'b0;
               timer_d     = '0;
               state_d     = WAIT_PS;
            end
         end
         default: state_d = IDLE;
      endcase

      // Lock loss abandons the run with no return sweep; a phase step that
      // completes in this same cycle is still reflected in phase_pos.
      if (lock_lost) begin
         ps_en_d   = 1'b0;
         trk_valid = 1'b0;
         error_d   = 1'b1;
         done_d    = 1'b1;
         busy_d    = 1'b0;
         state_d   = DONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         timer_q     <= '0;
         match_q     <= 1'b0;
         phase_pos_q <= '0;
         target_q    <= '0;
         ps_en_q     <= 1'b0;
         ps_incdec_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         timer_q     <= timer_d;
         match_q     <= match_d;
         phase_pos_q <= phase_pos_d;
         target_q    <= target_d;
         ps_en_q     <= ps_en_d;
         ps_incdec_q <= ps_incdec_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   syzygy_adc_eye_tracker #(
      .SW (SW)
   ) u_eye_tracker (
      .clk       (clk),
      .reset     (reset),
      .clear     (trk_clear),
      .valid     (trk_valid),
      .pass      (trk_pass),
      .step      (phase_pos_q),
      .eye_start (eye_start),
      .eye_width (eye_width)
   );

   assign ps_en     = ps_en_q;
   assign ps_incdec = ps_incdec_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign phase_pos = phase_pos_q;

endmodule

// File: tb/tb_syzygy_adc_phase_align.sv
// Directed bench: an MMCM phase-shift model moves a bench-side phase, and the
// ADC word matches the pattern only inside configured phase windows.
module tb_syzygy_adc_phase_align;

   localparam int DW         = 14;
   localparam int SW         = 8;
   localparam int PS_TIMEOUT = 1024;
   localparam int PS_DELAY   = 12;
   localparam logic [DW-1:0] PATTERN = 14'h2A5C;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          mmcm_locked = 1'b1;
   logic [DW-1:0] adc_data = '0;
   logic [DW-1:0] pattern = PATTERN;
   logic          ps_done = 1'b0;
   logic          ps_en;
   logic          ps_incdec;
   logic          busy;
   logic          done;
   logic          error;
   logic [SW-1:0] eye_start;
   logic [SW-1:0] eye_width;
   logic [SW-1:0] phase_pos;

   int n_cmp = 0;
   int n_bad = 0;

   // Bench-side MMCM and data source state.
   int cyc = 0;
   int ps_cnt = 0;
   bit ps_pend = 0;
   bit ps_dir = 0;
   bit ps_respond = 1;
   int inc_cnt = 0;
   int dec_cnt = 0;
   int mmcm_phase = 0;
   int lo0 = 40, hi0 = 79, lo1 = 1, hi1 = 0, glo = 1, ghi = 0;

   syzygy_adc_phase_align dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .mmcm_locked (mmcm_locked),
      .adc_data    (adc_data),
      .pattern     (pattern),
      .ps_done     (ps_done),
      .ps_en       (ps_en),
      .ps_incdec   (ps_incdec),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .eye_start   (eye_start),
      .eye_width   (eye_width),
      .phase_pos   (phase_pos)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] data_for(input int ph, input int c);
      if ((ph >= lo0 && ph <= hi0) || (ph >= lo1 && ph <= hi1)) return PATTERN;
      if (ph >= glo && ph <= ghi) return (c % 37 == 0) ? (PATTERN ^ 14'h2000) : PATTERN;
      return ~PATTERN;
   endfunction

   always @(negedge clk or posedge reset) begin
      if (reset) begin
         ps_cnt     = 0;
         ps_pend    = 0;
         ps_done    = 1'b0;
         mmcm_phase = 0;
      end else begin
         cyc++;
         ps_done = 1'b0;
         if (ps_cnt > 0) begin
            ps_cnt--;
            if (ps_cnt == 0) begin
               ps_done    = 1'b1;
               ps_pend    = 0;
               mmcm_phase = ps_dir ? mmcm_phase + 1 : mmcm_phase - 1;
            end
         end
         if (ps_en === 1'b1) begin
            if (ps_incdec) inc_cnt++; else dec_cnt++;
            n_cmp++;
            if (ps_pend) begin
               n_bad++;
               $display("FAIL ps_overlap: ps_en=1 with a shift outstanding at cycle %0d, want no overlap", cyc);
            end
            ps_pend = 1;
            ps_dir  = ps_incdec;
            if (ps_respond) ps_cnt = PS_DELAY;
         end
      end
      adc_data = data_for(mmcm_phase, cyc);
   end

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      inc_cnt = 0;
      dec_cnt = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int k = 0;
      while (done !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (done !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_wait_done: done=%b after %0d cycles, want 1", name, done, k);
      end
   endtask

   task automatic wait_phase(input string name, input int ph, input int budget);
      int k = 0;
      while (phase_pos !== SW'(ph) && k < budget) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (phase_pos !== SW'(ph)) begin
         n_bad++;
         $display("FAIL %s_wait_phase: phase_pos=%0d after %0d cycles, want %0d", name, phase_pos, k, ph);
      end
   endtask

   task automatic set_windows(input int a0, input int b0, input int a1, input int b1,
                              input int g0, input int g1);
      lo0 = a0; hi0 = b0; lo1 = a1; hi1 = b1; glo = g0; ghi = g1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++;
      if ({ps_en, ps_incdec, busy, done, error, eye_start, eye_width, phase_pos} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b, want all zero", {ps_en, ps_incdec, busy, done, error, eye_start, eye_width, phase_pos});
      end
      apply_reset();
      repeat (4) @(negedge clk);
      n_cmp++;
      if ({busy, done, ps_en} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_idle: busy/done/ps_en=%b, want 000", {busy, done, ps_en});
      end
   endtask

   task automatic test_nominal();
      apply_reset();
      set_windows(40, 79, 1, 0, 1, 0);
      pulse_start();
      n_cmp++;
      if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL nominal_busy: busy/done=%b, want 10", {busy, done}); end
      wait_done("nominal", 20000);
      n_cmp += 8;
      if (eye_start !== 8'd40) begin n_bad++; $display("FAIL nominal_eye_start: got %0d want 40", eye_start); end
      if (eye_width !== 8'd40) begin n_bad++; $display("FAIL nominal_eye_width: got %0d want 40", eye_width); end
      if (error !== 1'b0) begin n_bad++; $display("FAIL nominal_error: got %b want 0", error); end
      if (phase_pos !== 8'd59) begin n_bad++; $display("FAIL nominal_phase_pos: got %0d want 59", phase_pos); end
      if (mmcm_phase != 59) begin n_bad++; $display("FAIL nominal_mmcm_phase: got %0d want 59", mmcm_phase); end
      if (inc_cnt != 139) begin n_bad++; $display("FAIL nominal_inc_pulses: got %0d want 139", inc_cnt); end
      if (dec_cnt != 80) begin n_bad++; $display("FAIL nominal_dec_pulses: got %0d want 80", dec_cnt); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL nominal_busy_end: got %b want 0", busy); end
      repeat (20) @(negedge clk);
      n_cmp++;
      if ({done, phase_pos, ps_en} !== {1'b1, 8'd59, 1'b0}) begin
         n_bad++;
         $display("FAIL nominal_hold: done/phase/ps_en=%b/%0d/%b, want 1/59/0", done, phase_pos, ps_en);
      end
   endtask

   task automatic test_no_eye();
      apply_reset();
      set_windows(1, 0, 1, 0, 1, 0);
      pulse_start();
      wait_done("no_eye", 20000);
      n_cmp += 6;
      if (eye_width !== 8'd0) begin n_bad++; $display("FAIL no_eye_width: got %0d want 0", eye_width); end
      if (eye_start !== 8'd0) begin n_bad++; $display("FAIL no_eye_start: got %0d want 0", eye_start); end
      if (error !== 1'b1) begin n_bad++; $display("FAIL no_eye_error: got %b want 1", error); end
      if (phase_pos !== 8'd0) begin n_bad++; $display("FAIL no_eye_phase_pos: got %0d want 0", phase_pos); end
      if (dec_cnt != 139) begin n_bad++; $display("FAIL no_eye_dec_pulses: got %0d want 139", dec_cnt); end
      if (inc_cnt != 139) begin n_bad++; $display("FAIL no_eye_inc_pulses: got %0d want 139", inc_cnt); end
   endtask

   // Two equal windows plus a longer window corrupted by one word per compare.
   task automatic test_tie();
      apply_reset();
      set_windows(10, 19, 100, 109, 50, 69);
      pulse_start();
      wait_done("tie", 20000);
      n_cmp += 5;
      if (eye_start !== 8'd10) begin n_bad++; $display("FAIL tie_eye_start: got %0d want 10", eye_start); end
      if (eye_width !== 8'd10) begin n_bad++; $display("FAIL tie_eye_width: got %0d want 10", eye_width); end
      if (phase_pos !== 8'd14) begin n_bad++; $display("FAIL tie_phase_pos: got %0d want 14", phase_pos); end
      if (dec_cnt != 125) begin n_bad++; $display("FAIL tie_dec_pulses: got %0d want 125", dec_cnt); end
      if (error !== 1'b0) begin n_bad++; $display("FAIL tie_error: got %b want 0", error); end
   endtask

   task automatic test_ps_timeout();
      int k;
      apply_reset();
      set_windows(40, 79, 1, 0, 1, 0);
      ps_respond = 0;
      pulse_start();
      k = 0;
      while (ps_en !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
      n_cmp++;
      if (ps_en !== 1'b1) begin n_bad++; $display("FAIL timeout_first_ps_en: ps_en=%b after %0d cycles, want 1", ps_en, k); end
      k = 0;
      while (done !== 1'b1 && k < PS_TIMEOUT + 20) begin @(negedge clk); k++; end
      n_cmp += 3;
      if (k != PS_TIMEOUT) begin n_bad++; $display("FAIL timeout_latency: done after %0d cycles want %0d", k, PS_TIMEOUT); end
      if (error !== 1'b1) begin n_bad++; $display("FAIL timeout_error: got %b want 1", error); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout_busy: got %b want 0", busy); end
      repeat (40) @(negedge clk);
      n_cmp++;
      if (inc_cnt + dec_cnt != 1) begin n_bad++; $display("FAIL timeout_extra_ps_en: %0d pulses want 1", inc_cnt + dec_cnt); end
      ps_respond = 1;
   endtask

   task automatic test_lock_loss_restart();
      apply_reset();
      set_windows(40, 79, 1, 0, 1, 0);
      pulse_start();
      wait_phase("lock_loss", 50, 8000);
      mmcm_locked = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({done, error, busy} !== 3'b110) begin
         n_bad++;
         $display("FAIL lock_loss_flags: done/error/busy=%b want 110", {done, error, busy});
      end
      repeat (20) @(negedge clk);
      n_cmp += 2;
      if (dec_cnt != 0) begin n_bad++; $display("FAIL lock_loss_dec_pulses: got %0d want 0", dec_cnt); end
      if (phase_pos !== 8'd50) begin n_bad++; $display("FAIL lock_loss_phase_pos: got %0d want 50", phase_pos); end

      // Rerun sweeps from the current phase 50; the second start is mid-run.
      mmcm_locked = 1'b1;
      inc_cnt = 0;
      dec_cnt = 0;
      pulse_start();
      n_cmp++;
      if ({busy, done, error, eye_width} !== {3'b100, 8'd0}) begin
         n_bad++;
         $display("FAIL restart_clear: busy/done/error=%b eye_width=%0d, want 100 and 0", {busy, done, error}, eye_width);
      end
      wait_phase("restart", 55, 8000);
      pulse_start();
      wait_done("restart", 20000);
      n_cmp += 6;
      if (eye_start !== 8'd50) begin n_bad++; $display("FAIL restart_eye_start: got %0d want 50", eye_start); end
      if (eye_width !== 8'd30) begin n_bad++; $display("FAIL restart_eye_width: got %0d want 30", eye_width); end
      if (phase_pos !== 8'd64) begin n_bad++; $display("FAIL restart_phase_pos: got %0d want 64", phase_pos); end
      if (error !== 1'b0) begin n_bad++; $display("FAIL restart_error: got %b want 0", error); end
      if (inc_cnt != 89) begin n_bad++; $display("FAIL restart_inc_pulses: got %0d want 89", inc_cnt); end
      if (dec_cnt != 75) begin n_bad++; $display("FAIL restart_dec_pulses: got %0d want 75", dec_cnt); end
   endtask

   task automatic test_midrun_reset();
      int k;
      apply_reset();
      set_windows(40, 79, 1, 0, 1, 0);
      pulse_start();
      wait_phase("midrun", 45, 8000);
      k = 0;
      while (ps_en !== 1'b1 && k < 200) begin @(negedge clk); k++; end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (eye_width !== 8'd6) begin n_bad++; $display("FAIL midrun_pre_eye_width: got %0d want 6", eye_width); end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({ps_en, ps_incdec, busy, done, error, eye_start, eye_width, phase_pos} !== '0) begin
         n_bad++;
         $display("FAIL midrun_async_clear: got %b, want all zero", {ps_en, ps_incdec, busy, done, error, eye_start, eye_width, phase_pos});
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      n_cmp++;
      if ({busy, done, ps_en} !== 3'b000) begin n_bad++; $display("FAIL midrun_idle: busy/done/ps_en=%b want 000", {busy, done, ps_en}); end
      inc_cnt = 0;
      dec_cnt = 0;
      pulse_start();
      wait_done("midrun_rerun", 20000);
      n_cmp += 5;
      if (eye_start !== 8'd40) begin n_bad++; $display("FAIL midrun_eye_start: got %0d want 40", eye_start); end
      if (eye_width !== 8'd40) begin n_bad++; $display("FAIL midrun_eye_width: got %0d want 40", eye_width); end
      if (phase_pos !== 8'd59) begin n_bad++; $display("FAIL midrun_phase_pos: got %0d want 59", phase_pos); end
      if (inc_cnt != 139) begin n_bad++; $display("FAIL midrun_inc_pulses: got %0d want 139", inc_cnt); end
      if (dec_cnt != 80) begin n_bad++; $display("FAIL midrun_dec_pulses: got %0d want 80", dec_cnt); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_no_eye();
      test_tie();
      test_ps_timeout();
      test_lock_loss_restart();
      test_midrun_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/syzygy_adc_phase_align.md
Name: syzygy_adc_phase_align

Overview:
- Calibrates the capture phase of the ADC DCO clocking path after MMCM lock.
- Sweeps the MMCM dynamic phase shift (PSEN/PSINCDEC/PSDONE) across one DCO period.
- At each phase step, checks the deserialized ADC test-pattern word. Finds the longest passing window and parks the phase at its centre.
- Runs in the divided (1/4-rate) data clock domain, which also drives the MMCM PSCLK. Software starts it and reads status.

Parameters:
- DATA_WIDTH, 14, width of the deserialized ADC sample word compared against the pattern.
- NUM_STEPS, 140, number of phase positions swept (0..NUM_STEPS-1). Default is one 2 ns DCO period at 1/56 VCO-period resolution.
- SETTLE_CYCLES, 16, clk cycles waited after each phase step before comparing.
- COMPARE_CYCLES, 64, consecutive matching words required for a step to pass.
- PS_TIMEOUT, 1024, maximum clk cycles from ps_en to ps_done before declaring an error.
- SW, $clog2(NUM_STEPS+1), width of step-index outputs (derived).

Ports:
- clk  in  1  divided ADC data clock; also drives MMCM PSCLK.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse; begins calibration when idle.
- mmcm_locked  in  1  MMCM LOCKED, already synchronous to clk.
- adc_data  in  DATA_WIDTH  deserialized sample word.
- pattern  in  DATA_WIDTH  expected test-pattern word; held static during a run.
- ps_done  in  1  MMCM PSDONE.
- ps_en  out  1  MMCM PSEN; one-cycle pulse per step.
- ps_incdec  out  1  MMCM PSINCDEC; 1 = increment, 0 = decrement.
- busy  out  1  calibration in progress.
- done  out  1  calibration finished; level output.
- error  out  1  failure flag; valid when done=1.
- eye_start  out  SW  first step of the best window.
- eye_width  out  SW  length of the best window; 0 = none found.
- phase_pos  out  SW  current tracked phase step.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; internal counters and eye registers 0.
- Reset does not restore the MMCM phase. Firmware must also reset the MMCM, which is treated as phase_pos=0.
- start is accepted only in IDLE or DONE. Acceptance clears done, error, eye_start, eye_width and run trackers, and sets busy the next cycle. start while busy is ignored.
- FSM transitions:
  - IDLE/DONE -> WAIT_LOCK on start.
  - WAIT_LOCK -> SETTLE when mmcm_locked=1. There is no timeout here.
  - SETTLE: count SETTLE_CYCLES, then -> COMPARE.
  - COMPARE: count COMPARE_CYCLES. The step passes iff adc_data==pattern on every cycle. Record the result into the tracker, then:
    - -> STEP if phase_pos < NUM_STEPS-1;
    - otherwise -> EVAL.
  - STEP: ps_en=1, ps_incdec=1 for exactly one cycle -> WAIT_PS.
  - WAIT_PS: on ps_done, update phase_pos ±1 and go -> SETTLE (sweep) or -> RETURN (return phase).
  - EVAL:
    - If eye_width>0: target = eye_start + (eye_width-1)/2 (floor), error=0.
    - Otherwise: target = 0, error=1.
    - Then -> RETURN.
  - RETURN:
    - If phase_pos==target -> DONE.
    - Otherwise pulse ps_en=1, ps_incdec=0 for one cycle -> WAIT_PS.
  - DONE: busy=0, done=1. Outputs are held until the next accepted start.
- Only one phase-shift operation is outstanding at a time. ps_en never reasserts before ps_done is received. ps_incdec is stable while ps_en=1.
- Tracker behaviour:
  - On a pass: if cur_len==0, cur_start=phase_pos; then cur_len+1. If the new cur_len > eye_width (strictly), copy cur_start and cur_len into eye_start and eye_width.
  - On a fail: cur_len=0.
  - Ties keep the earliest window. Windows do not wrap from step NUM_STEPS-1 to 0.
- PS timeout: a counter starts at ps_en. If it reaches PS_TIMEOUT without ps_done, set error=1 -> DONE immediately. phase_pos is no longer trustworthy.
- Lock loss: mmcm_locked=0 in any state other than IDLE, WAIT_LOCK or DONE sets error=1 -> DONE, with no return sweep.
- Simultaneous ps_done and timeout expiry in the same cycle: ps_done wins.
- All counters saturate-free. Widths are sized by $clog2 of their limit +1.

Decomposition:
- Package syzygy_adc_align_pkg: FSM state enum (IDLE, WAIT_LOCK, SETTLE, COMPARE, STEP, WAIT_PS, EVAL, RETURN, DONE) and localparam defaults for the timing constants.
- One sub-module: syzygy_adc_eye_tracker. Inputs: clk, reset, clear, valid, pass, step index. Outputs: eye_start, eye_width. Holds the longest-run logic.

Test Plan:
- Nominal sweep:
  - Stimulus: MMCM model returns ps_done 12 cycles after ps_en; data matches only for phase 40..79; start.
  - Required response: eye_start=40, eye_width=40, error=0. Exactly 139 inc pulses, then 80 dec pulses; final phase_pos=59; done=1, busy=0.
- No eye:
  - Stimulus: data never matches.
  - Required response: eye_width=0, error=1, 139 dec pulses, phase_pos=0, done=1.
- Tie:
  - Stimulus: passing windows 10..19 and 100..109.
  - Required response: eye_start=10, eye_width=10, phase_pos=14 at done.
- PS timeout:
  - Stimulus: ps_done never returns after the first inc.
  - Required response: error=1, done=1 exactly PS_TIMEOUT cycles after ps_en; no further ps_en.
- Lock loss and restart:
  - Stimulus: drop mmcm_locked at step 50.
  - Required response: error=1, done=1 within 1 cycle, no dec pulses.
  - Then: start is ignored while busy during a nominal rerun; after done, a new start clears done/error and reruns.
- Mid-run reset:
  - Stimulus: assert reset during WAIT_PS.
  - Required response: all outputs 0 asynchronously; FSM in IDLE; a subsequent start from phase_pos=0 completes nominally.
